// File: rtl/fixed_mac_array.sv
// fixed_mac_array: pipelined multi-lane signed MAC with framed
// accumulation, optional saturation and a valid/ready result port.
module fixed_mac_array #(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 32,
  parameter bit SATURATE  = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [LANES*A_WIDTH-1:0]   in_a,
  input  logic [LANES*B_WIDTH-1:0]   in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_acc,
  output logic                       out_overflow
);

  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int MSB = ACC_WIDTH - 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  if (ACC_WIDTH < PW + $clog2(LANES)) begin : g_width_check
    $error("fixed_mac_array: ACC_WIDTH too small");
  end

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Operand capture: multipliers start from flops, not fetch logic.
  logic                     v0, f0, l0;
  logic [LANES*A_WIDTH-1:0] a0;
  logic [LANES*B_WIDTH-1:0] b0;

  always_ff @(posedge clock) begin
    if (reset) begin
      v0 <= 1'b0;
      f0 <= 1'b0;
      l0 <= 1'b0;
      a0 <= '0;
      b0 <= '0;
    end else if (!stall) begin
      v0 <= in_valid;
      f0 <= in_first;
      l0 <= in_last;
      a0 <= in_a;
      b0 <= in_b;
    end
  end

  logic signed [PW-1:0] prod    [LANES];
  logic signed [PW-1:0] p1_prod [LANES];
  logic                 v1, f1, l1;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = PW'($signed(a0[i*A_WIDTH +: A_WIDTH]))
              * PW'($signed(b0[i*B_WIDTH +: B_WIDTH]));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1 <= 1'b0;
      f1 <= 1'b0;
      l1 <= 1'b0;
      for (int i = 0; i < LANES; i++) p1_prod[i] <= '0;
    end else if (!stall) begin
      v1 <= v0;
      f1 <= f0;
      l1 <= l0;
      for (int i = 0; i < LANES; i++) p1_prod[i] <= prod[i];
    end
  end

  logic signed [ACC_WIDTH-1:0] tree;
  logic signed [ACC_WIDTH-1:0] s2;
  logic                        v2, f2, l2;

  always_comb begin
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      tree = tree + ACC_WIDTH'(p1_prod[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v2 <= 1'b0;
      f2 <= 1'b0;
      l2 <= 1'b0;
      s2 <= '0;
    end else if (!stall) begin
      v2 <= v1;
      f2 <= f1;
      l2 <= l1;
      s2 <= tree;
    end
  end

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] base, raw, nxt;
  logic                        sticky, sticky_base, step_ovf;

  always_comb begin
    base     = f2 ? '0 : acc;
    raw      = base + s2;
    step_ovf = (base[MSB] == s2[MSB]) && (raw[MSB] != base[MSB]);
    nxt      = raw;
    if (SATURATE && step_ovf) begin
      nxt = base[MSB] ? ACC_MIN : ACC_MAX;
    end
    sticky_base = f2 ? 1'b0 : sticky;
  end

  // Accumulator is zeroed after each last beat, so the next frame
  // starts clean even without an explicit first.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc    <= '0;
      sticky <= 1'b0;
    end else if (!stall && v2) begin
      if (l2) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else begin
        acc    <= nxt;
        sticky <= sticky_base | step_ovf;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_acc      <= '0;
      out_overflow <= 1'b0;
    end else if (!stall && v2 && l2) begin
      out_valid    <= 1'b1;
      out_acc      <= nxt;
      out_overflow <= sticky_base | step_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_mac_array.sv
// Directed self-checking bench for fixed_mac_array: default config
// plus two 18-bit instances (saturating and wrapping).
module tb_fixed_mac_array;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;

  logic        in_ready, out_valid, out_overflow;
  logic [31:0] out_acc;
  logic        s_in_ready, s_out_valid, s_ovf;
  logic [17:0] s_acc;
  logic        w_in_ready, w_out_valid, w_ovf;
  logic [17:0] w_acc;

  int passed = 0;
  int total = 0;

  always #5 clock = ~clock;

  fixed_mac_array dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_overflow(out_overflow)
  );

  fixed_mac_array #(.ACC_WIDTH(18), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_first(in_first), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_acc(s_acc), .out_overflow(s_ovf)
  );

  fixed_mac_array #(.ACC_WIDTH(18), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_first(in_first), .in_last(in_last),
    .in_a(in_a), .in_b(in_b),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_acc(w_acc), .out_overflow(w_ovf)
  );

  function automatic logic [31:0] pk(input int x0, x1, x2, x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  task automatic send(input logic [31:0] a, b,
                      input logic f, l, output bit ok);
    int n = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_first = f;
    in_last = l;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    ok = in_ready;
    @(posedge clock);
  endtask

  task automatic idle();
    @(negedge clock);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(input int max, output bit ok);
    int n = 0;
    while (!out_valid && n < max) begin
      @(negedge clock);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic count_out(input int cycles, output int cnt,
                           output logic [31:0] val);
    cnt = 0;
    val = '0;
    repeat (cycles) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        cnt++;
        val = out_acc;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (out_acc !== 32'd0) $display("FAIL rst_acc: got %0d want 0", out_acc);
    else passed++;
    total++;
    if (out_overflow !== 1'b0) $display("FAIL rst_ovf: got %b want 0", out_overflow);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
    else passed++;
    total++;
    if (s_out_valid !== 1'b0) $display("FAIL rst_sat_valid: got %b want 0", s_out_valid);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    send(pk(1, 2, 3, 4), pk(5, 6, 7, 8), 1'b1, 1'b1, ok);
    idle();
    total++;
    if (!ok) $display("FAIL single_accept: got 0 want 1");
    else passed++;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clock);
      total++;
      if (out_valid !== (n == 3))
        $display("FAIL single_lat%0d: got %b want %b", n, out_valid, n == 3);
      else passed++;
    end
    total++;
    if ($signed(out_acc) !== 70)
      $display("FAIL single_acc: got %0d want 70", $signed(out_acc));
    else passed++;
    total++;
    if (out_overflow !== 1'b0) $display("FAIL single_ovf: got %b want 0", out_overflow);
    else passed++;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_taken: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit ok, allok;
    allok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(pk(-1, -1, -1, -1), pk(3, 3, 3, 3), i == 0, i == 2, ok);
      allok &= ok;
    end
    send(pk(2, 0, 0, 0), pk(2, 0, 0, 0), 1'b0, 1'b1, ok);
    allok &= ok;
    idle();
    total++;
    if (!allok) $display("FAIL b2b_accept: got 0 want 1");
    else passed++;
    wait_out(10, ok);
    total++;
    if (!ok) $display("FAIL b2b_timeout: got no result want one");
    else passed++;
    total++;
    if ($signed(out_acc) !== -36)
      $display("FAIL b2b_acc1: got %0d want -36", $signed(out_acc));
    else passed++;
    total++;
    if (out_overflow !== 1'b0) $display("FAIL b2b_ovf1: got %b want 0", out_overflow);
    else passed++;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b1 || $signed(out_acc) !== 4)
      $display("FAIL b2b_acc2: got v=%b %0d want v=1 4", out_valid, $signed(out_acc));
    else passed++;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_saturation();
    bit ok;
    send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b1, 1'b0, ok);
    idle();
    repeat (2) @(negedge clock);
    send(pk(-128, -128, -128, -128), pk(-128, -128, -128, -128), 1'b0, 1'b1, ok);
    idle();
    wait_out(10, ok);
    total++;
    if (!ok || s_out_valid !== 1'b1 || w_out_valid !== 1'b1)
      $display("FAIL sat_timeout: got v=%b/%b/%b want 1/1/1", out_valid, s_out_valid, w_out_valid);
    else passed++;
    total++;
    if (s_acc !== 18'h1FFFF) $display("FAIL sat_acc: got %h want 1ffff", s_acc);
    else passed++;
    total++;
    if (s_ovf !== 1'b1) $display("FAIL sat_ovf: got %b want 1", s_ovf);
    else passed++;
    total++;
    if (w_acc !== 18'h20000) $display("FAIL wrap_acc: got %h want 20000", w_acc);
    else passed++;
    total++;
    if (w_ovf !== 1'b1) $display("FAIL wrap_ovf: got %b want 1", w_ovf);
    else passed++;
    total++;
    if (out_acc !== 32'd131072 || out_overflow !== 1'b0)
      $display("FAIL wide_acc: got %0d ovf=%b want 131072 ovf=0", out_acc, out_overflow);
    else passed++;
    send(pk(1, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b1, ok);
    idle();
    wait_out(10, ok);
    total++;
    if (!ok || s_acc !== 18'd1 || s_ovf !== 1'b0)
      $display("FAIL sat_sticky_clr: got %0d ovf=%b want 1 ovf=0", s_acc, s_ovf);
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_mid_first();
    bit ok;
    send(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b1, 1'b0, ok);
    send(pk(7, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b1, ok);
    idle();
    wait_out(10, ok);
    total++;
    if (!ok || $signed(out_acc) !== 7)
      $display("FAIL midfirst_acc: got v=%b %0d want v=1 7", ok, $signed(out_acc));
    else passed++;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) $display("FAIL midfirst_extra: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit ok, allok;
    int got;
    logic [31:0] vals [4];
    allok = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      send(pk(10 * k, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b1, ok);
      allok &= ok;
    end
    idle();
    total++;
    if (!allok) $display("FAIL bp_accept: got 0 want 1");
    else passed++;
    wait_out(10, ok);
    total++;
    if (!ok) $display("FAIL bp_timeout: got no result want one");
    else passed++;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (in_ready !== 1'b0) $display("FAIL bp_ready%0d: got %b want 0", c, in_ready);
      else passed++;
      total++;
      if (out_valid !== 1'b1 || out_acc !== 32'd10)
        $display("FAIL bp_hold%0d: got v=%b %0d want v=1 10", c, out_valid, out_acc);
      else passed++;
      @(negedge clock);
    end
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && out_ready) begin
        if (got < 4) vals[got] = out_acc;
        got++;
      end
      @(negedge clock);
    end
    total++;
    if (got !== 4) $display("FAIL bp_count: got %0d want 4", got);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (got < 4 || vals[k] !== 32'(10 * (k + 1)))
        $display("FAIL bp_val%0d: got %0d want %0d", k, vals[k], 10 * (k + 1));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cnt;
    logic [31:0] val;
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b1, 1'b0, ok);
    send(pk(1, 1, 1, 1), pk(1, 1, 1, 1), 1'b0, 1'b0, ok);
    @(negedge clock);
    in_valid = 1'b0;
    in_first = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0 || out_acc !== 32'd0 || out_overflow !== 1'b0)
      $display("FAIL rstmid_out: got v=%b %0d ovf=%b want 0 0 0", out_valid, out_acc, out_overflow);
    else passed++;
    total++;
    if (in_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", in_ready);
    else passed++;
    reset = 1'b0;
    send(pk(5, 0, 0, 0), pk(1, 0, 0, 0), 1'b1, 1'b1, ok);
    idle();
    count_out(10, cnt, val);
    total++;
    if (cnt !== 1) $display("FAIL rstmid_count: got %0d want 1", cnt);
    else passed++;
    total++;
    if (val !== 32'd5) $display("FAIL rstmid_acc: got %0d want 5", val);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_mid_first();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
